// File: rtl/mvu_recv_fifo_if.sv
// rtl/mvu_recv_fifo_if.sv - lane-in / consumer-out handshake bundle for the MVU receive FIFO
//
// Purpose: groups the crossbar lane strobe/data and the consumer valid/ready
//          handshake of one MVU receive buffer.
// Signals:
//   recv_en    lane word strobe (no backpressure)
//   recv_word  lane data word
//   out_valid  head word available
//   out_ready  consumer accepts head word
//   out_word   head word (zero when not valid)
// Modports:
//   master  drives the lane and the consumer ready (crossbar + MVU side)
//   slave   the FIFO itself

interface mvu_recv_fifo_if #(
    parameter int W = 128
);
    logic         recv_en;
    logic [W-1:0] recv_word;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_word;

    modport master (
        output recv_en,
        output recv_word,
        output out_ready,
        input  out_valid,
        input  out_word
    );

    modport slave (
        input  recv_en,
        input  recv_word,
        input  out_ready,
        output out_valid,
        output out_word
    );
endinterface

// File: rtl/mvu_recv_fifo.sv
// rtl/mvu_recv_fifo.sv - per-MVU first-word-fall-through receive FIFO behind the crossbar
//
// Purpose: captures one interconnect lane into a D-deep FWFT FIFO, presents
//          the head word on a valid/ready handshake, reports occupancy and
//          almost-full to the sender, and flags dropped words.
// Ports:
//   clk          rising-edge clock
//   clr_n        synchronous active-low reset
//   bus          lane input and consumer handshake (slave modport)
//   count        occupancy 0..D
//   almost_full  count >= AF
//   overflow     sticky dropped-word flag
//   ovf_clr      clears overflow (a same-cycle drop wins)

module mvu_recv_fifo #(
    parameter int W  = 128,
    parameter int D  = 16,
    parameter int AF = 12
) (
    input  logic                 clk,
    input  logic                 clr_n,
    mvu_recv_fifo_if.slave       bus,
    output logic [$clog2(D):0]   count,
    output logic                 almost_full,
    output logic                 overflow,
    input  logic                 ovf_clr
);
    localparam int P = $clog2(D);
    localparam logic [P:0] DEPTH  = (P+1)'(D);
    localparam logic [P:0] AF_LVL = (P+1)'(AF);

    logic [W-1:0] mem_q [D];
    logic [P-1:0] wr_ptr_q, wr_ptr_d;
    logic [P-1:0] rd_ptr_q, rd_ptr_d;
    logic [P:0]   count_q, count_d;
    logic         ovf_q, ovf_d;

    logic valid;
    logic push;
    logic pop;
    logic drop;

    assign valid = (count_q != '0);
    assign pop   = valid && bus.out_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push  = bus.recv_en && ((count_q != DEPTH) || pop);
    assign drop  = bus.recv_en && !push;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + P'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + P'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (P+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (P+1)'(1);
        end
        // Set has priority over clear so a drop is never lost.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; a strobe during reset must not land in memory.
    always_ff @(posedge clk) begin
        if (clr_n && push) begin
            mem_q[wr_ptr_q] <= bus.recv_word;
        end
    end

    assign bus.out_valid = valid;
    assign bus.out_word  = valid ? mem_q[rd_ptr_q] : '0;
    assign count         = count_q;
    assign almost_full   = (count_q >= AF_LVL);
    assign overflow      = ovf_q;
endmodule

// File: tb/tb_mvu_recv_fifo.sv
// tb/tb_mvu_recv_fifo.sv - directed self-checking bench for mvu_recv_fifo

module tb_mvu_recv_fifo;
    localparam int W  = 128;
    localparam int D  = 16;
    localparam int AF = 12;
    localparam int P  = $clog2(D);

    logic         clk;
    logic         clr_n;
    logic [P:0]   count;
    logic         almost_full;
    logic         overflow;
    logic         ovf_clr;
    int           errors;
    int           checks;

    mvu_recv_fifo_if #(.W(W)) bus ();

    mvu_recv_fifo #(.W(W), .D(D), .AF(AF)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .bus         (bus.slave),
        .count       (count),
        .almost_full (almost_full),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr_n         = 1'b0;
        bus.recv_en   = 1'b1;
        bus.recv_word = W'(128'h55);
        bus.out_ready = 1'b0;
        ovf_clr       = 1'b0;
        step();
        step();
        clr_n       = 1'b1;
        bus.recv_en = 1'b0;
        checks++;
        if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        checks++;
        if (bus.out_word !== '0) begin errors++; $display("FAIL reset_word got=%h exp=0", bus.out_word); end
        checks++;
        if (overflow !== 1'b0 || almost_full !== 1'b0) begin
            errors++; $display("FAIL reset_flags got ovf=%b af=%b exp 0 0", overflow, almost_full);
        end
        step();
        checks++;
        if (count !== 5'd0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_idle got count=%0d valid=%b exp 0 0", count, bus.out_valid);
        end
    endtask

    task automatic test_pass_through();
        bus.out_ready = 1'b1;
        bus.recv_en   = 1'b1;
        bus.recv_word = W'(128'hA5);
        step();
        bus.recv_en = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_word !== W'(128'hA5)) begin
            errors++; $display("FAIL pass_head got valid=%b word=%h exp 1 a5", bus.out_valid, bus.out_word);
        end
        step();
        checks++;
        if (count !== 5'd0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL pass_pop got count=%0d valid=%b exp 0 0", count, bus.out_valid);
        end
    endtask

    task automatic fill(input int base);
        bus.out_ready = 1'b0;
        for (int i = 0; i < D; i++) begin
            bus.recv_en   = 1'b1;
            bus.recv_word = W'(base + i);
            step();
        end
        bus.recv_en = 1'b0;
    endtask

    task automatic test_fill_overflow();
        bus.out_ready = 1'b0;
        for (int i = 0; i < D; i++) begin
            bus.recv_en   = 1'b1;
            bus.recv_word = W'(i);
            step();
            if (i == AF - 2) begin
                checks++;
                if (almost_full !== 1'b0) begin errors++; $display("FAIL af_below got=%b exp=0", almost_full); end
            end
            if (i == AF - 1) begin
                checks++;
                if (almost_full !== 1'b1) begin errors++; $display("FAIL af_at got=%b exp=1", almost_full); end
            end
        end
        checks++;
        if (count !== 5'd16) begin errors++; $display("FAIL fill_count got=%0d exp=16", count); end
        bus.recv_word = W'(16);
        step();
        bus.recv_en = 1'b0;
        checks++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            errors++; $display("FAIL drop got ovf=%b count=%0d exp 1 16", overflow, count);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < D; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_word !== W'(i)) begin
                errors++; $display("FAIL drain_%0d got valid=%b word=%0d exp 1 %0d", i, bus.out_valid, bus.out_word, i);
            end
            step();
        end
        bus.out_ready = 1'b0;
        checks++;
        if (count !== 5'd0 || bus.out_valid !== 1'b0 || almost_full !== 1'b0) begin
            errors++; $display("FAIL drain_empty got count=%0d valid=%b af=%b exp 0 0 0", count, bus.out_valid, almost_full);
        end
    endtask

    task automatic test_full_push_pop();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
        fill(0);
        bus.recv_en   = 1'b1;
        bus.recv_word = W'(99);
        bus.out_ready = 1'b1;
        step();
        bus.recv_en = 1'b0;
        checks++;
        if (count !== 5'd16 || overflow !== 1'b0 || bus.out_word !== W'(1)) begin
            errors++; $display("FAIL full_pushpop got count=%0d ovf=%b head=%0d exp 16 0 1", count, overflow, bus.out_word);
        end
        for (int i = 1; i <= D; i++) begin
            checks++;
            if (bus.out_word !== W'((i == D) ? 99 : i)) begin
                errors++; $display("FAIL pp_drain_%0d got=%0d exp=%0d", i, bus.out_word, (i == D) ? 99 : i);
            end
            step();
        end
        bus.out_ready = 1'b0;
        checks++;
        if (count !== 5'd0) begin errors++; $display("FAIL pp_empty got=%0d exp=0", count); end
    endtask

    task automatic test_ovf_clear_race();
        fill(200);
        bus.recv_en   = 1'b1;
        bus.recv_word = W'(128'hEE);
        step();
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL race_set got=%b exp=1", overflow); end
        ovf_clr = 1'b1;
        step();
        checks++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            errors++; $display("FAIL race_setwins got ovf=%b count=%0d exp 1 16", overflow, count);
        end
        bus.recv_en = 1'b0;
        step();
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL race_clear got=%b exp=0", overflow); end
        checks++;
        if (bus.out_word !== W'(200)) begin errors++; $display("FAIL race_head got=%0d exp=200", bus.out_word); end
    endtask

    task automatic test_reset_mid_stream();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) step();
        bus.out_ready = 1'b0;
        checks++;
        if (count !== 5'd7 || bus.out_word !== W'(209)) begin
            errors++; $display("FAIL mid_pre got count=%0d head=%0d exp 7 209", count, bus.out_word);
        end
        clr_n         = 1'b0;
        bus.recv_en   = 1'b1;
        bus.recv_word = W'(128'h77);
        step();
        clr_n       = 1'b1;
        bus.recv_en = 1'b0;
        checks++;
        if (count !== 5'd0 || bus.out_valid !== 1'b0 || bus.out_word !== '0) begin
            errors++; $display("FAIL mid_reset got count=%0d valid=%b word=%h exp 0 0 0", count, bus.out_valid, bus.out_word);
        end
        bus.recv_en   = 1'b1;
        bus.recv_word = W'(128'h3C);
        step();
        bus.recv_en = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_word !== W'(128'h3C) || count !== 5'd1) begin
            errors++; $display("FAIL mid_push got valid=%b word=%h count=%0d exp 1 3c 1", bus.out_valid, bus.out_word, count);
        end
        checks++;
        if (dut.mem_q[0] !== W'(128'h3C)) begin
            errors++; $display("FAIL mid_mem0 got=%h exp=3c", dut.mem_q[0]);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_pass_through();
        test_fill_overflow();
        test_full_push_pop();
        test_ovf_clear_race();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mvu_recv_fifo.md
Name: mvu_recv_fifo

Overview:
- Per-MVU receive buffer placed directly downstream of the MVU crossbar interconnect.
- Captures one lane's registered recv_en/recv_word stream and holds it in a first-word-fall-through FIFO.
- Presents the data to the consuming MVU over a valid/ready handshake.
- The crossbar has no backpressure, so the block reports occupancy and almost-full to the sender-side controller, and flags any dropped word with a sticky overflow bit.

Parameters:
- W, 128, data word width; equals the interconnect lane width.
- D, 16, FIFO depth in words; power of two, at least 2.
- AF, 12, almost-full threshold; 1 <= AF <= D.
- Local constant: P = $clog2(D), the pointer width.

Ports:
- clk  input  1  clock; all logic on its rising edge.
- clr_n  input  1  reset; synchronous, active-low, sampled on the rising edge of clk.
- recv_en  input  1  word strobe from one interconnect lane.
- recv_word  input  W  data from the same lane.
- out_valid  output  1  head word available.
- out_ready  input  1  consumer accepts the head word this cycle.
- out_word  output  W  head word.
- count  output  P+1  current occupancy, 0..D.
- almost_full  output  1  high when count >= AF.
- overflow  output  1  sticky: a word was dropped.
- ovf_clr  input  1  clears overflow.

Behaviour:
- Reset: clr_n low at a rising edge forces the following, regardless of any other input in that cycle:
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - out_valid=0, almost_full=0 (AF>=1), out_word=0.
- Memory contents are not reset.
- Storage: D x W register array, written at mem[wr_ptr].
- Pointers are P bits and wrap naturally from D-1 to 0.
- Handshake definitions:
  - push = recv_en && (count<D || pop).
  - pop = out_valid && out_ready.
- out_valid = (count != 0), decoded from registered count.
- out_word = mem[rd_ptr] when out_valid, else all zeros. This is first-word-fall-through: no read latency.
- Latency: a word strobed at edge t is visible on out_valid/out_word after edge t.
  - Empty FIFO: first valid cycle is t+1.
  - There is no same-cycle bypass from recv_word to out_word.
- Each cycle, on the rising edge:
  - push: mem[wr_ptr]<=recv_word; wr_ptr<=wr_ptr+1.
  - pop: rd_ptr<=rd_ptr+1.
  - count update: count+1 on push only, count-1 on pop only, unchanged on both or neither.
- out_ready while out_valid=0 is ignored; no pointer or count change.
- Full (count==D):
  - recv_en with pop in the same cycle: word accepted, count stays D, head advances.
  - recv_en without pop: word dropped, pointers and memory unchanged, overflow<=1.
- Overflow flag:
  - Stays set until ovf_clr.
  - ovf_clr alone clears it at the next edge.
  - ovf_clr in the same cycle as a drop: set wins, overflow stays 1.
- almost_full = (count >= AF), combinational from registered count, so it updates one edge after the push/pop that crosses AF.
- Reset mid-operation:
  - All queued words are discarded.
  - A recv_en in the reset cycle is not stored.
  - The first word accepted after reset is written at mem[0].
- count is never outside 0..D; underflow is impossible because pop requires out_valid.

Test Plan:
1. Reset then idle. Hold clr_n=0 for 2 cycles with recv_en=1 and recv_word=W'h55, then release. Required: count=0, out_valid=0, out_word=0, overflow=0, and nothing is stored.
2. Single pass-through. With out_ready=1, strobe recv_word=W'hA5 at edge t. Required:
   - out_valid=1 and out_word=W'hA5 during cycle t+1.
   - Popped at edge t+1, leaving count=0 and out_valid=0 after it.
3. Fill with the consumer stalled. Set out_ready=0 and push 0..15 (D=16). Required:
   - almost_full rises after the 12th push.
   - count=16.
   - A 17th push with value 16 sets overflow=1 and leaves count=16.
   - Draining yields exactly 0..15 in order, with wrap-around verified.
4. Full with simultaneous push and pop. Fill to 16, then drive recv_en=1 with value 99 and out_ready=1. Required:
   - Head 0 is consumed and count stays 16.
   - overflow stays 0.
   - 99 exits last after values 1..15.
5. Overflow clear race. With overflow=1 and count=16, drive ovf_clr=1 together with a dropped push. Required: overflow stays 1. Next cycle, ovf_clr=1 with no push gives overflow=0.
6. Reset mid-stream. With count=7, pulse clr_n low for one edge while recv_en=1. Required:
   - count=0 and out_valid=0.
   - The next pushed word W'h3C appears on out_word one cycle later and is read from mem[0].
